lfsr_4_checker: RTL

LFSR_4_CHECKER -- requirements
Module: lfsr_4_checker

---
 rtl/lfsr_4_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lfsr_4_checker.sv
// Checker for a 4-bit LFSR stream: acquires lock on the incoming sequence,
// then flywheels its own prediction and flags mispredicted samples.
module lfsr_4_checker #(
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [3:0] data_in,
  output logic       locked,
  output logic       error,
  output logic [7:0] err_count,
  output logic [3:0] expected
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned EW = 8;

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  function automatic logic [DW-1:0] step(input logic [DW-1:0] s);
    return {s[2], s[1], s[0] ^ s[3], s[3]};
  endfunction

  logic [1:0]    r_state;
  logic [CW-1:0] r_match_cnt;
  logic [CW-1:0] r_miss_cnt;
  logic [DW-1:0] r_expected;
  logic          r_locked;
  logic          r_error;
  logic [EW-1:0] r_err_count;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_match_nxt;
  logic [CW-1:0] w_miss_nxt;
  logic [DW-1:0] w_expected_nxt;
  logic          w_locked_nxt;
  logic          w_error_nxt;
  logic [EW-1:0] w_err_count_nxt;
  logic [CW-1:0] w_match_inc;
  logic [CW-1:0] w_miss_inc;

  assign w_match_inc = r_match_cnt + CW'(1);
  assign w_miss_inc  = r_miss_cnt + CW'(1);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SEARCH;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_expected  <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_expected  <= w_expected_nxt;
      r_locked    <= w_locked_nxt;
      r_error     <= w_error_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  // Next-state and next-output logic; idle cycles hold everything
  always_comb begin
    w_state_nxt     = r_state;
    w_match_nxt     = r_match_cnt;
    w_miss_nxt      = r_miss_cnt;
    w_expected_nxt  = r_expected;
    w_locked_nxt    = r_locked;
    w_error_nxt     = 1'b0;
    w_err_count_nxt = r_err_count;

    if (valid_in) begin
      case (r_state)
        S_SEARCH: begin
          if (data_in != '0) begin
            w_expected_nxt = step(data_in);
            w_match_nxt    = '0;
            w_state_nxt    = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (data_in == r_expected) begin
            w_expected_nxt = step(data_in);
            w_match_nxt    = w_match_inc;
            if (w_match_inc == CW'(LOCK_COUNT)) begin
              w_state_nxt  = S_LOCKED;
              w_locked_nxt = 1'b1;
              w_miss_nxt   = '0;
            end
          end else if (data_in != '0) begin
            w_expected_nxt = step(data_in);
            w_match_nxt    = '0;
          end else begin
            w_match_nxt = '0;
            w_state_nxt = S_SEARCH;
          end
        end
        S_LOCKED: begin
          // Flywheel: prediction advances from itself, never from data_in
          w_expected_nxt = step(r_expected);
          if (data_in != r_expected) begin
            w_error_nxt     = 1'b1;
            w_err_count_nxt = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + EW'(1);
            w_miss_nxt      = w_miss_inc;
            if (w_miss_inc == CW'(UNLOCK_COUNT)) begin
              w_state_nxt  = S_SEARCH;
              w_locked_nxt = 1'b0;
              w_miss_nxt   = '0;
              w_match_nxt  = '0;
            end
          end else begin
            w_miss_nxt = '0;
          end
        end
        default: begin
          w_state_nxt  = S_SEARCH;
          w_locked_nxt = 1'b0;
          w_match_nxt  = '0;
          w_miss_nxt   = '0;
        end
      endcase
    end
  end

  assign locked    = r_locked;
  assign error     = r_error;
  assign err_count = r_err_count;
  assign expected  = r_expected;

endmodule
